imm_encoder: RTL

- Streaming inverse of the immediate extractor: takes a base instruction word, an immediate type and a 32-bit immediate value.
- Scatters the immediate into that type's instruction bit fields and range-checks it.
- Feeds the self-test/boot instruction generator and the branch-target patcher; output is a complete RV32I instruction word.
- Two-stage valid/ready pipeline, full throughput.

---
 rtl/imm_encoder.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/imm_encoder.sv
// Two-stage valid/ready encoder that scatters an immediate into an RV32I instruction word.
// Optional macro IMM_ENC_DROP_EN: errored items are counted but never presented.
module imm_encoder #(
   parameter int unsigned ERR_CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          in_base,
   input  logic [2:0]           in_imm_type,
   input  logic [31:0]          in_imm,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_instr,
   output logic                 out_err,
   output logic [ERR_CNT_W-1:0] err_count
);

   typedef enum logic [2:0] {
      IMM_I     = 3'b000,
      IMM_B     = 3'b001,
      IMM_S     = 3'b010,
      IMM_U     = 3'b011,
      IMM_J     = 3'b100,
      IMM_SHAMT = 3'b101,
      IMM_CSR   = 3'b110,
      IMM_RSVD  = 3'b111
   } imm_type_e;

   logic        s1_valid;
   logic [31:0] s1_base;
   logic [31:0] s1_imm;
   imm_type_e   s1_type;

   logic        s2_valid;
   logic [31:0] s2_instr;

   logic        s2_adv;
   logic [31:0] enc_instr;
   logic        enc_err;

   // S2 can take a new word when empty or when its word leaves this cycle
   assign s2_adv   = !s2_valid || out_ready;
   assign in_ready = !s1_valid || s2_adv;

   always_comb begin
      enc_instr = s1_base;
      enc_err   = 1'b0;
      case (s1_type)
         IMM_I: begin
            enc_instr[31:20] = s1_imm[11:0];
            enc_err = (s1_imm[31:11] != '0) && (s1_imm[31:11] != '1);
         end
         IMM_S: begin
            enc_instr[31:25] = s1_imm[11:5];
            enc_instr[11:7]  = s1_imm[4:0];
            enc_err = (s1_imm[31:11] != '0) && (s1_imm[31:11] != '1);
         end
         IMM_B: begin
            enc_instr[31]    = s1_imm[12];
            enc_instr[30:25] = s1_imm[10:5];
            enc_instr[11:8]  = s1_imm[4:1];
            enc_instr[7]     = s1_imm[11];
            enc_err = ((s1_imm[31:12] != '0) && (s1_imm[31:12] != '1)) || s1_imm[0];
         end
         IMM_U: begin
            enc_instr[31:12] = s1_imm[31:12];
            enc_err = (s1_imm[11:0] != '0);
         end
         IMM_J: begin
            enc_instr[31]    = s1_imm[20];
            enc_instr[30:21] = s1_imm[10:1];
            enc_instr[20]    = s1_imm[11];
            enc_instr[19:12] = s1_imm[19:12];
            enc_err = ((s1_imm[31:20] != '0) && (s1_imm[31:20] != '1)) || s1_imm[0];
         end
         IMM_SHAMT: begin
            enc_instr[24:20] = s1_imm[4:0];
            enc_err = (s1_imm[31:5] != '0);
         end
         IMM_CSR: begin
            enc_instr[19:15] = s1_imm[4:0];
            enc_err = (s1_imm[31:5] != '0);
         end
         default: enc_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_base  <= '0;
         s1_imm   <= '0;
         s1_type  <= IMM_I;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_base <= in_base;
            s1_imm  <= in_imm;
            s1_type <= imm_type_e'(in_imm_type);
         end
      end
   end

`ifdef IMM_ENC_DROP_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_instr <= '0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid && !enc_err;
         if (s1_valid) s2_instr <= enc_instr;
      end
   end

   assign out_err = 1'b0;
`else
   logic s2_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_instr <= '0;
         s2_err   <= 1'b0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_instr <= enc_instr;
            s2_err   <= enc_err;
         end
      end
   end

   assign out_err = s2_err;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count <= '0;
      end else if (s1_valid && s2_adv && enc_err && (err_count != '1)) begin
         err_count <= err_count + 1'b1;
      end
   end

   assign out_valid = s2_valid;
   assign out_instr = s2_instr;

endmodule
